// File: rtl/mem_subword_pkg.sv
// Shared types and helpers for the sub-word load/store read-modify-write unit.
package mem_subword_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHK,
        ST_RD,
        ST_WAIT,
        ST_WR,
        ST_RESP
    } state_t;

    // Number of address bits selecting a byte lane within a memory word.
    function automatic int unsigned lane_bits(input int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// Byte-lane steering: store merge into a memory word, load extraction with extension, lane mask.
module mem_lane_merge
    import mem_subword_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0]            word,
    input  logic [DATA_W-1:0]            wdata,
    input  logic [lane_bits(DATA_W)-1:0] lane,
    input  logic [1:0]                   size,
    input  logic                         is_unsigned,
    output logic [DATA_W-1:0]            merged_c,
    output logic [DATA_W-1:0]            load_data_c,
    output logic [DATA_W/8-1:0]          be_c
);

    localparam int unsigned NLANES = DATA_W / 8;
    localparam int unsigned LANE_W = lane_bits(DATA_W);

    logic [LANE_W-1:0] base;
    logic [DATA_W-1:0] shifted;

    // Store path: replace the selected lanes with the right-aligned store data.
    always_comb begin
        merged_c = word;
        be_c     = '0;
        for (int unsigned k = 0; k < NLANES; k++) begin
            if (size == SZ_BYTE) begin
                be_c[k] = (LANE_W'(k) == lane);
                merged_c[8*k +: 8] = be_c[k] ? wdata[7:0] : word[8*k +: 8];
            end else if (size == SZ_HALF) begin
                be_c[k] = ((LANE_W'(k) >> 1) == (lane >> 1));
                merged_c[8*k +: 8] = be_c[k] ? wdata[8*(k%2) +: 8] : word[8*k +: 8];
            end else begin
                be_c[k] = 1'b1;
                merged_c[8*k +: 8] = wdata[8*k +: 8];
            end
        end
    end

    // Load path: shift the addressed lane(s) down, then zero- or sign-extend.
    always_comb begin
        case (size)
            SZ_BYTE: base = lane;
            SZ_HALF: base = lane & ~LANE_W'(1);
            default: base = '0;
        endcase
        shifted = word >> {base, 3'b000};
        case (size)
            SZ_BYTE: load_data_c = is_unsigned ? DATA_W'(shifted[7:0])
                                               : {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_data_c = is_unsigned ? DATA_W'(shifted[15:0])
                                               : {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
            default: load_data_c = word;
        endcase
    end

endmodule

// File: rtl/mem_subword_rmw.sv
// Sequential sub-word load/store unit between datapath and word-addressed memory.
// Define MEM_SUBWORD_BYTE_ENABLE_EN to add mem_be and write stores without a read.
module mem_subword_rmw
    import mem_subword_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic                mem_rd,
    output logic                mem_wr,
`ifdef MEM_SUBWORD_BYTE_ENABLE_EN
    output logic [DATA_W/8-1:0] mem_be,
`endif
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int unsigned LANE_W = lane_bits(DATA_W);
    localparam int unsigned CNT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LAT - 1);

    state_t              state, next_state;
    logic                r_we, r_unsigned, r_mis;
    logic [1:0]          r_size;
    logic [LANE_W-1:0]   r_lane;
    logic [DATA_W-1:0]   r_wdata;
    logic [CNT_W-1:0]    wait_cnt;

    logic                req_mis_c, r_is_word_c, direct_wr_c;
    logic [DATA_W-1:0]   merge_word_c, merged_c, load_data_c;
    logic [DATA_W/8-1:0] be_c;

    logic                ready_d, resp_valid_d, resp_err_d, mem_rd_d, mem_wr_d;
    logic [DATA_W-1:0]   resp_rdata_d, mem_wdata_d;

    assign req_mis_c   = ((req_size == SZ_HALF) && req_addr[0])
                      || ((req_size != SZ_BYTE) && (req_size != SZ_HALF)
                          && (req_addr[LANE_W-1:0] != '0));
    assign r_is_word_c = (r_size != SZ_BYTE) && (r_size != SZ_HALF);

`ifdef MEM_SUBWORD_BYTE_ENABLE_EN
    logic [DATA_W/8-1:0] be_d;
    // Stores never read; unselected lanes are masked off by mem_be.
    assign direct_wr_c  = r_we;
    assign merge_word_c = r_we ? '0 : mem_rdata;
`else
    logic unused_be_c;
    assign unused_be_c  = ^be_c;
    assign direct_wr_c  = r_we && r_is_word_c;
    assign merge_word_c = mem_rdata;
`endif

    mem_lane_merge #(
        .DATA_W(DATA_W)
    ) u_lane_merge (
        .word        (merge_word_c),
        .wdata       (r_wdata),
        .lane        (r_lane),
        .size        (r_size),
        .is_unsigned (r_unsigned),
        .merged_c    (merged_c),
        .load_data_c (load_data_c),
        .be_c        (be_c)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (req_valid) next_state = ST_CHK;
            ST_CHK: begin
                if (r_mis)            next_state = ST_RESP;
                else if (direct_wr_c) next_state = ST_WR;
                else                  next_state = ST_RD;
            end
            ST_RD:   next_state = ST_WAIT;
            ST_WAIT: if (wait_cnt == LAST_CNT) next_state = r_we ? ST_WR : ST_RESP;
            ST_WR:   next_state = ST_RESP;
            ST_RESP: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, keyed on the state being entered.
    always_comb begin
        ready_d      = (next_state == ST_IDLE);
        resp_valid_d = (next_state == ST_RESP);
        resp_err_d   = resp_valid_d && r_mis;
        resp_rdata_d = '0;
        if ((state == ST_WAIT) && (next_state == ST_RESP)) resp_rdata_d = load_data_c;
        mem_rd_d     = (next_state == ST_RD);
        mem_wr_d     = (next_state == ST_WR);
        mem_wdata_d  = mem_wr_d ? merged_c : mem_wdata;
`ifdef MEM_SUBWORD_BYTE_ENABLE_EN
        be_d         = mem_wr_d ? be_c : '0;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
`ifdef MEM_SUBWORD_BYTE_ENABLE_EN
            mem_be     <= '0;
`endif
            r_we       <= 1'b0;
            r_unsigned <= 1'b0;
            r_mis      <= 1'b0;
            r_size     <= 2'b00;
            r_lane     <= '0;
            r_wdata    <= '0;
            wait_cnt   <= '0;
        end else begin
            req_ready  <= ready_d;
            resp_valid <= resp_valid_d;
            resp_rdata <= resp_rdata_d;
            resp_err   <= resp_err_d;
            mem_rd     <= mem_rd_d;
            mem_wr     <= mem_wr_d;
            mem_wdata  <= mem_wdata_d;
`ifdef MEM_SUBWORD_BYTE_ENABLE_EN
            mem_be     <= be_d;
`endif
            wait_cnt   <= (state == ST_WAIT) ? wait_cnt + CNT_W'(1) : '0;
            if ((state == ST_IDLE) && req_valid) begin
                r_we       <= req_we;
                r_unsigned <= req_unsigned;
                r_mis      <= req_mis_c;
                r_size     <= req_size;
                r_lane     <= req_addr[LANE_W-1:0];
                r_wdata    <= req_wdata;
                mem_addr   <= {req_addr[ADDR_W-1:LANE_W], LANE_W'(0)};
            end
        end
    end

endmodule

// File: tb/tb_mem_subword_rmw.sv
// Self-checking bench for mem_subword_rmw (DATA_W=32, MEM_LAT=2).
module tb_mem_subword_rmw;
    import mem_subword_pkg::*;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned MEM_LAT = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, mem_rd, mem_wr;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef MEM_SUBWORD_BYTE_ENABLE_EN
    logic [3:0]  mem_be;
`endif

    always #5 clk = ~clk;

    mem_subword_rmw #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_rd(mem_rd), .mem_wr(mem_wr),
`ifdef MEM_SUBWORD_BYTE_ENABLE_EN
        .mem_be(mem_be),
`endif
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Memory: returns cur_word only in the cycle MEM_LAT cycles after mem_rd.
    logic [31:0] cur_word = 32'h0;
    logic [1:0]  rd_pipe;
    always @(posedge clk or negedge reset_n)
        if (!reset_n) rd_pipe <= 2'b00;
        else          rd_pipe <= {rd_pipe[0], mem_rd};
    assign mem_rdata = rd_pipe[1] ? cur_word : 32'hDEAD_0BAD;

    int          n_rd = 0, n_wr = 0, n_both = 0, n_resp = 0;
    logic [31:0] last_wr_data = 32'h0, last_wr_addr = 32'h0, last_rd_addr = 32'h0;
    always @(negedge clk) begin
        if (mem_rd) begin n_rd++; last_rd_addr = mem_addr; end
        if (mem_wr) begin n_wr++; last_wr_data = mem_wdata; last_wr_addr = mem_addr; end
        if (mem_rd && mem_wr) n_both++;
        if (resp_valid) n_resp++;
    end

    int n_checks = 0, n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        logic [31:0] wword;
        int          lat;
        int          nrd;
        int          nwr;
    } exp_t;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] word;
        exp_t        e;
    } vec_t;

    // Reference: byte-array view of the word, little-endian lanes.
    function automatic exp_t model(input logic we, input logic [1:0] size, input logic uns,
                                   input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic [31:0] word);
        exp_t        e;
        int          nbytes, off;
        logic [7:0]  b[4];
        logic [31:0] v;
        nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        off    = int'(addr % 4);
        for (int i = 0; i < 4; i++) b[i] = word[8*i +: 8];
        e.err = (off % nbytes) != 0;
        e.rdata = 32'h0;
        e.wword = word;
        if (e.err) begin
            e.lat = 2; e.nrd = 0; e.nwr = 0;
        end else if (we) begin
            for (int i = 0; i < nbytes; i++) b[off+i] = wdata[8*i +: 8];
            e.wword = {b[3], b[2], b[1], b[0]};
            e.nwr = 1;
            e.nrd = (nbytes == 4) ? 0 : 1;
            e.lat = (nbytes == 4) ? 3 : 4 + int'(MEM_LAT);
        end else begin
            v = 32'h0;
            for (int i = 0; i < nbytes; i++) v = v + (32'(b[off+i]) << (8*i));
            if (!uns && nbytes < 4 && b[off+nbytes-1][7]) v = v - (32'd1 << (8*nbytes));
            e.rdata = v;
            e.lat = 3 + int'(MEM_LAT); e.nrd = 1; e.nwr = 0;
        end
        return e;
    endfunction

    task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] word, input exp_t e);
        int          rd0, wr0, both0, lat, waited;
        logic [31:0] rdata;
        logic        err, rdy_resp, rdy_after;
        cur_word = word;
        waited = 0;
        while (!req_ready && waited < 20) begin @(negedge clk); waited++; end
        check({tag, " ready_idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0; req_wdata = $urandom; req_addr = $urandom;
        req_size = 2'($urandom_range(0, 2)); req_we = ~we; req_unsigned = ~uns;
        rd0 = n_rd; wr0 = n_wr; both0 = n_both;
        lat = -1; rdata = 32'h0; err = 1'b0; rdy_resp = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = k; rdata = resp_rdata; err = resp_err; rdy_resp = req_ready;
                break;
            end
        end
        @(negedge clk); #1;
        rdy_after = req_ready;
        check({tag, " latency"}, 32'(lat), 32'(e.lat));
        check({tag, " rdata"}, rdata, e.rdata);
        check({tag, " err"}, 32'(err), 32'(e.err));
        check({tag, " rd_count"}, 32'(n_rd - rd0), 32'(e.nrd));
        check({tag, " wr_count"}, 32'(n_wr - wr0), 32'(e.nwr));
        check({tag, " rd_wr_overlap"}, 32'(n_both - both0), 32'd0);
        check({tag, " ready_in_resp"}, 32'(rdy_resp), 32'd0);
        check({tag, " ready_after"}, 32'(rdy_after), 32'd1);
        if (e.nwr > 0) begin
            check({tag, " wr_data"}, last_wr_data, e.wword);
            check({tag, " wr_addr"}, last_wr_addr, addr & ~32'd3);
        end
        if (e.nrd > 0) check({tag, " rd_addr"}, last_rd_addr, addr & ~32'd3);
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] word, input logic err,
                                input logic [31:0] rdata, input logic [31:0] wword,
                                input int lat, input int nrd, input int nwr);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata; v.word = word;
        v.e.err = err; v.e.rdata = rdata; v.e.wword = wword;
        v.e.lat = lat; v.e.nrd = nrd; v.e.nwr = nwr;
        return v;
    endfunction

    vec_t vecs[10];

    initial begin
        int          rd0, wr0, resp0;
        logic        we, uns;
        logic [1:0]  size;
        logic [31:0] addr, wdata, word;

        vecs[0] = mk(1, 2'd0, 0, 32'h0000_1001, 32'h0000_00AB, 32'h1122_3344, 0, 32'h0, 32'h1122_AB44, 6, 1, 1);
        vecs[1] = mk(1, 2'd1, 0, 32'h0000_2002, 32'h0000_BEEF, 32'h1122_3344, 0, 32'h0, 32'hBEEF_3344, 6, 1, 1);
        vecs[2] = mk(0, 2'd0, 0, 32'h0000_3003, 32'h0,         32'h80FF_0000, 0, 32'hFFFF_FF80, 32'h0, 5, 1, 0);
        vecs[3] = mk(0, 2'd0, 1, 32'h0000_3003, 32'h0,         32'h80FF_0000, 0, 32'h0000_0080, 32'h0, 5, 1, 0);
        vecs[4] = mk(0, 2'd1, 0, 32'h0000_4001, 32'h0,         32'h1234_5678, 1, 32'h0, 32'h0, 2, 0, 0);
        vecs[5] = mk(1, 2'd2, 0, 32'h0000_5004, 32'hDEAD_BEEF, 32'h1234_5678, 0, 32'h0, 32'hDEAD_BEEF, 3, 0, 1);
        vecs[6] = mk(0, 2'd1, 0, 32'h0000_6002, 32'h0,         32'h80FF_0000, 0, 32'hFFFF_80FF, 32'h0, 5, 1, 0);
        vecs[7] = mk(0, 2'd1, 1, 32'h0000_7000, 32'h0,         32'h1234_F00D, 0, 32'h0000_F00D, 32'h0, 5, 1, 0);
        vecs[8] = mk(0, 2'd2, 0, 32'h0000_8008, 32'h0,         32'h1234_5678, 0, 32'h1234_5678, 32'h0, 5, 1, 0);
        vecs[9] = mk(1, 2'd2, 0, 32'h0000_9002, 32'hCAFE_F00D, 32'h1234_5678, 1, 32'h0, 32'h0, 2, 0, 0);

        reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        check("rst req_ready", 32'(req_ready), 32'd1);
        check("rst resp_valid", 32'(resp_valid), 32'd0);
        check("rst resp_rdata", resp_rdata, 32'h0);
        check("rst resp_err", 32'(resp_err), 32'd0);
        check("rst mem_rd", 32'(mem_rd), 32'd0);
        check("rst mem_wr", 32'(mem_wr), 32'd0);
        check("rst mem_addr", mem_addr, 32'h0);
        check("rst mem_wdata", mem_wdata, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++)
            do_req($sformatf("vec%0d", i), vecs[i].we, vecs[i].size, vecs[i].uns,
                   vecs[i].addr, vecs[i].wdata, vecs[i].word, vecs[i].e);

        for (int i = 0; i < 150; i++) begin
            we = 1'($urandom); uns = 1'($urandom); size = 2'($urandom_range(0, 2));
            addr = $urandom; wdata = $urandom; word = $urandom;
            do_req($sformatf("rnd%0d", i), we, size, uns, addr, wdata, word,
                   model(we, size, uns, addr, wdata, word));
        end

        // Reset during WAIT of a byte store: request is dropped silently.
        cur_word = 32'h1122_3344;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h0000_A001; req_wdata = 32'h0000_00AB;
        @(posedge clk); #1;
        req_valid = 1'b0;
        wr0 = n_wr; resp0 = n_resp; rd0 = n_rd;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mid_rst mem_rd_issued", 32'(n_rd - rd0), 32'd1);
        check("mid_rst ready_in_reset", 32'(req_ready), 32'd1);
        check("mid_rst mem_wr_in_reset", 32'(mem_wr), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        check("mid_rst no_write", 32'(n_wr - wr0), 32'd0);
        check("mid_rst no_resp", 32'(n_resp - resp0), 32'd0);
        check("mid_rst ready_after", 32'(req_ready), 32'd1);
        do_req("post_rst", 1'b1, 2'd0, 1'b0, 32'h0000_B002, 32'h0000_0055, 32'h1122_3344,
               model(1'b1, 2'd0, 1'b0, 32'h0000_B002, 32'h0000_0055, 32'h1122_3344));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_subword_rmw.md
Name: mem_subword_rmw

Overview:
- Sequential successor to the combinational sub-word store merger.
- Serves one load/store request at a time from the datapath. Performs read-modify-write for byte/halfword stores and lane extraction with sign/zero extension for loads.
- Sits between the MIPS multicycle control/datapath and the word-addressed data memory. Generalised in data width and memory read latency; detects misalignment.

Parameters:
- DATA_W, 32, memory word width in bits; power of two, >=16.
- ADDR_W, 32, byte-address width.
- MEM_LAT, 1, memory read latency in cycles after mem_rd; >=1.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  size_t: SZ_BYTE, SZ_HALF, SZ_WORD (full DATA_W).
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse; no backpressure.
- resp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned request, qualified by resp_valid.
- mem_rd  out  1  one-cycle read strobe.
- mem_wr  out  1  one-cycle write strobe.
- mem_addr  out  ADDR_W  word-aligned address; low log2(DATA_W/8) bits are 0.
- mem_wdata  out  DATA_W  merged write word.
- mem_rdata  in  DATA_W  read data, valid MEM_LAT cycles after mem_rd.

Behaviour:
- Reset values: req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; mem_rd=0; mem_wr=0; mem_addr=0; mem_wdata=0. All outputs are registered.
- Reset asserted mid-transaction returns to IDLE immediately, drops strobes, and drops the request with no response.
- Lanes are little-endian. Byte lane k occupies bits [8k+7:8k], where k = req_addr[log2(DATA_W/8)-1:0]. A halfword occupies the lane pair starting at the even lane. Merged word = mem_rdata with the selected lanes replaced by the low bits of req_wdata.
- Misalignment: SZ_HALF with addr[0]=1, or SZ_WORD with any low lane bit set.
- Request acceptance: a request is accepted on the clock edge where req_valid and req_ready are both high (call it t0). All request fields are captured at t0.
- FSM states: IDLE, CHK, RD, WAIT, WR, RESP.
- IDLE -> CHK on accept.
- CHK (t1):
  - If misaligned -> RESP with resp_err=1 and no memory access.
  - Else if word store -> WR, with mem_wdata = req_wdata.
  - Else -> RD.
- RD: mem_rd=1 for one cycle with mem_addr -> WAIT.
- WAIT: lasts exactly MEM_LAT cycles. mem_rdata is sampled on the last WAIT cycle.
  - Load -> RESP; resp_rdata = extracted lanes, extended per req_unsigned (word loads pass through).
  - Sub-word store -> WR with the merged word.
- WR: mem_wr=1 for one cycle with mem_addr/mem_wdata -> RESP.
- RESP: resp_valid=1 for one cycle -> IDLE. req_ready is high again the cycle after RESP.
- Latency from accept to resp_valid:
  - Error: 2 cycles.
  - Word store: 3 cycles.
  - Load: 3+MEM_LAT cycles.
  - Sub-word store: 4+MEM_LAT cycles.
- req_valid while busy is ignored; the requester holds it.
- mem_rd and mem_wr are never high in the same cycle.

Optional Feature:
- MEM_SUBWORD_BYTE_ENABLE_EN.
- Defined:
  - Adds output mem_be [DATA_W/8-1:0], reset 0.
  - Stores of any size go CHK -> WR with no read. mem_wdata carries req_wdata replicated into the selected lanes; mem_be marks those lanes.
  - Sub-word store latency becomes 3 cycles.
  - Loads are unchanged; mem_be is 0 outside WR.
- Undefined: no mem_be port; stores use read-modify-write as above.

Decomposition:
- Package mem_subword_pkg:
  - size_t enum: SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - state_t enum.
  - Function lane_bits(DATA_W).
- Sub-module mem_lane_merge (combinational): inputs word, wdata, lane offset, size, unsigned flag. Outputs merged word, extended load data, byte-enable mask.

Test Plan (DATA_W=32, MEM_LAT=2):
- Byte store, addr 0x...1, wdata 0xAB, memory word 0x11223344 -> mem_rd; mem_wr writes 0x1122AB44; resp_valid 6 cycles after accept; resp_err=0.
- Halfword store, addr 0x...2, wdata 0xBEEF, memory word 0x11223344 -> writes 0xBEEF3344.
- Byte load, addr 0x...3, memory 0x80FF0000:
  - Signed -> resp_rdata 0xFFFFFF80.
  - Unsigned -> resp_rdata 0x00000080.
- Misaligned halfword load at 0x...1 -> no mem_rd/mem_wr; resp_err=1 two cycles after accept; req_ready returns the next cycle.
- Word store 0xDEADBEEF at 0x...4 -> no mem_rd; mem_wr with 0xDEADBEEF; resp 3 cycles after accept.
- reset_n pulled low during WAIT of a byte store -> mem_wr never asserts, no resp_valid, req_ready=1 after release. A following request completes normally.
